// File: rtl/shift_step_ctrl.sv
// -----------------------------------------------------------------------------
// shift_step_ctrl
//
// Step sequencer for the 4-position rotating LED shift register. It produces
// the one-cycle step strobe at one of four rates, and handles run/pause/idle
// control from the board inputs. While paused it blinks the LED row through
// o_led_en, which the top level ANDs with the shift register output.
//
// Ports
//   clk        system clock, rising edge
//   i_rst      asynchronous reset, active low
//   i_enable   1 = active, 0 = force IDLE
//   i_speed    period select (PER0..PER3), sampled every cycle
//   i_pause    debounced button level; a rising edge toggles RUN/PAUSE
//   o_valid    one-cycle step strobe to the shift register
//   o_led_en   LED gate: 1 = show shift register, 0 = blank
//   o_state    00 IDLE, 01 RUN, 10 PAUSE
//   o_step_cnt steps issued since reset or IDLE, modulo 256
// -----------------------------------------------------------------------------
module shift_step_ctrl #(
    parameter int unsigned CNT_W = 32,
    parameter int unsigned PER0  = 50000000,
    parameter int unsigned PER1  = 25000000,
    parameter int unsigned PER2  = 12500000,
    parameter int unsigned PER3  = 6250000
) (
    input  logic       clk,
    input  logic       i_rst,
    input  logic       i_enable,
    input  logic [1:0] i_speed,
    input  logic       i_pause,
    output logic       o_valid,
    output logic       o_led_en,
    output logic [1:0] o_state,
    output logic [7:0] o_step_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_last;
    logic               pause_q;
    logic               pause_edge;
    logic               wrap;

    // Terminal count for a period. Periods of 0 or 1 both mean "every cycle",
    // so they collapse to a terminal count of 0.
    function automatic logic [CNT_W-1:0] last_count(input int unsigned per);
        if (per <= 1) begin
            return '0;
        end
        return CNT_W'(per - 1);
    endfunction

    always_comb begin
        cnt_last = last_count(PER0);
        case (i_speed)
            2'd1:    cnt_last = last_count(PER1);
            2'd2:    cnt_last = last_count(PER2);
            2'd3:    cnt_last = last_count(PER3);
            default: cnt_last = last_count(PER0);
        endcase
    end

    // >= rather than == so a speed change to a shorter period while the
    // counter is already past the new terminal count wraps on the next cycle
    // instead of running all the way round the counter.
    assign wrap       = (cnt >= cnt_last);
    assign pause_edge = i_pause & ~pause_q;
    assign o_state    = state;

    always_ff @(posedge clk or negedge i_rst) begin
        if (!i_rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            pause_q    <= 1'b0;
            o_valid    <= 1'b0;
            o_led_en   <= 1'b1;
            o_step_cnt <= 8'd0;
        end else begin
            // The edge detector tracks the button in every state, so a press
            // held through IDLE does not register as an edge on entry to RUN.
            pause_q <= i_pause;
            o_valid <= 1'b0;

            if (!i_enable) begin
                // Disable outranks everything, including a pending wrap.
                state      <= ST_IDLE;
                cnt        <= '0;
                o_led_en   <= 1'b1;
                o_step_cnt <= 8'd0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state      <= ST_RUN;
                        cnt        <= '0;
                        o_led_en   <= 1'b1;
                        o_step_cnt <= 8'd0;
                    end

                    ST_RUN: begin
                        o_led_en <= 1'b1;
                        if (pause_edge) begin
                            // A pause edge swallows a coincident wrap: no strobe.
                            state <= ST_PAUSE;
                            cnt   <= '0;
                        end else if (wrap) begin
                            cnt        <= '0;
                            o_valid    <= 1'b1;
                            o_step_cnt <= o_step_cnt + 8'd1;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end

                    ST_PAUSE: begin
                        if (pause_edge) begin
                            state    <= ST_RUN;
                            cnt      <= '0;
                            o_led_en <= 1'b1;
                        end else if (wrap) begin
                            // Same wrap rule as RUN, used as the blink timebase.
                            cnt      <= '0;
                            o_led_en <= ~o_led_en;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end

                    default: begin
                        // Encoding 11 is unreachable; recover through IDLE.
                        state      <= ST_IDLE;
                        cnt        <= '0;
                        o_led_en   <= 1'b1;
                        o_step_cnt <= 8'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/shift_step_ctrl.md
Name: shift_step_ctrl

Overview:
- Sequencer for the 4-position rotating shift register in the blink-and-move LED path.
- Generates the one-cycle `i_valid` step strobe for the shift register at one of four selectable rates.
- Provides run / pause / idle control from board inputs.
- Produces a blink gate (`o_led_en`) so the LED row flashes while paused.
- Sits between the board switches/button and the shift register; the shift register's `o_data` is ANDed with `o_led_en` at top level.

Parameters:
- CNT_W, 32, width of the prescaler counter and the period parameters.
- PER0, 50000000, step period in clk cycles for `i_speed`=0.
- PER1, 25000000, step period in clk cycles for `i_speed`=1.
- PER2, 12500000, step period in clk cycles for `i_speed`=2.
- PER3, 6250000, step period in clk cycles for `i_speed`=3.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- i_rst  in  1  asynchronous, active-low reset (asserted at 0); deassertion is assumed already synchronised to clk.
- i_enable  in  1  level; 1 = block active, 0 = force IDLE.
- i_speed  in  2  period select; sampled every cycle.
- i_pause  in  1  level from a debounced button; a rising edge toggles RUN/PAUSE.
- o_valid  out  1  one-cycle step strobe to the shift register.
- o_led_en  out  1  LED gate: 1 = show shift register, 0 = blank.
- o_state  out  2  current state: 00 IDLE, 01 RUN, 10 PAUSE.
- o_step_cnt  out  8  number of steps issued since reset or IDLE; wraps 255->0.

Behaviour:
- **Reset** (`i_rst`=0, immediate, asynchronous): state IDLE, counter 0, `o_valid`=0, `o_led_en`=1, `o_state`=00, `o_step_cnt`=0, pause-edge register=0.
- **Reset mid-operation:** all state is lost; an in-flight `o_valid` is dropped. Outputs are registered; no combinational path from inputs to outputs.
- **Effective period:** `P` = PERn selected by `i_speed`. PERn values of 0 or 1 are treated as 1, giving a strobe every cycle.
- **Edge detection:** rising edge of `i_pause` = `i_pause` AND NOT its value registered on the previous cycle. The registered copy updates in every state.
- **IDLE:**
  - Counter held at 0, `o_valid`=0, `o_led_en`=1, `o_step_cnt` cleared to 0.
  - `i_enable`=1 -> RUN on the next edge.
  - A pause edge in IDLE is ignored.
- **RUN:**
  - Counter increments each cycle.
  - When counter >= P-1: counter <- 0, `o_valid`=1 for exactly that cycle, `o_step_cnt` +1.
  - Otherwise `o_valid`=0.
  - `o_led_en`=1.
  - With period P, strobes are exactly P cycles apart. The first strobe occurs P cycles after entering RUN from IDLE.
- **PAUSE:**
  - Counter keeps running with the same wrap rule but `o_valid` stays 0.
  - On each wrap, `o_led_en` toggles, giving a blink with half-period P.
  - `o_step_cnt` is held.
- **Pause edge transitions:**
  - RUN -> PAUSE: counter <- 0, `o_led_en` <- 1.
  - PAUSE -> RUN: counter <- 0, `o_led_en` <- 1. First strobe after resume comes P cycles later.
- **Speed change mid-count:** takes effect immediately through the >= compare. If the counter is already >= new P-1, the wrap (and strobe in RUN) happens on the next cycle; there is no lockup or long wrap.
- **Priority, highest first:** reset > `i_enable`=0 > pause edge > counter wrap.
  - `i_enable`=0 in RUN or PAUSE -> IDLE next edge. No strobe is issued that cycle, even if the counter would have wrapped.
  - Pause edge and wrap in the same RUN cycle -> go to PAUSE and suppress the strobe; `o_step_cnt` is unchanged.
- **`o_step_cnt` width:** modulo 256; 255 + 1 = 0 with no flag.
- State encoding 11 is unreachable; if entered, go to IDLE next cycle.

Test Plan (CNT_W=8, PER0=4, PER1=8, PER2=16, PER3=2):
- Reset with `i_enable`=1, `i_speed`=0; release -> IDLE one cycle, then RUN. `o_valid` pulses 4 cycles after RUN entry and every 4 cycles after; `o_step_cnt` reads 1, 2, 3 on successive pulses.
- In RUN at `i_speed`=2 with counter=10, switch to `i_speed`=0 -> strobe on the next cycle, then every 4 cycles.
- Pause edge in RUN -> `o_state`=10 with no strobes. `o_led_en` goes 1 for 4 cycles, then 0 for 4 cycles, repeating; `o_step_cnt` held. A second edge -> RUN, `o_led_en`=1, next strobe 4 cycles later.
- Pause edge coincident with a wrap cycle -> no `o_valid`, state PAUSE. `i_enable`=0 coincident with a wrap -> no `o_valid`, IDLE, `o_step_cnt`=0.
- `i_speed`=3 in RUN for 600 cycles -> `o_valid` every 2 cycles; `o_step_cnt` wraps 255->0 after 256 strobes.
- Assert `i_rst`=0 asynchronously between edges during a strobe cycle -> `o_valid` drops immediately; all outputs take reset values before the next clk edge.
